// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - bus/decoder handshake bundle for the instruction prefetch queue
interface instr_prefetch_queue_if #(
    parameter int AW = 16
);
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [15:0]   mem_data;
    logic          ir_valid;
    logic [31:0]   ir;
    logic [AW-1:0] ir_pc;
    logic          ir_take;

    modport master (
        input  flush, flush_addr, mem_ready, mem_data, ir_take,
        output mem_req, mem_addr, ir_valid, ir, ir_pc
    );

    modport slave (
        output flush, flush_addr, mem_ready, mem_data, ir_take,
        input  mem_req, mem_addr, ir_valid, ir, ir_pc
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - fetches 16-bit word pairs into a DEPTH-entry queue of 32-bit instructions
module instr_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_prefetch_queue_if.master bus
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [15:0]   hold_q, hold_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW:0]   count_post;
    logic [31:0]   ir_mem_q [DEPTH];
    logic [AW-1:0] pc_mem_q [DEPTH];
    logic          push;
    logic          pop;

    assign pop        = bus.ir_take && (count_q != '0);
    assign push       = (state_q == FETCH_HI) && bus.mem_ready;
    // Occupancy after this edge's push/pop; decides whether another fetch may start.
    assign count_post = count_q + (PW+1)'(push) - (PW+1)'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        hold_d     = hold_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.flush) begin
            state_d    = IDLE;
            fetch_pc_d = bus.flush_addr;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            count_d = count_post;
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            case (state_q)
                IDLE: begin
                    if (count_post < FULL) state_d = FETCH_LO;
                end
                FETCH_LO: begin
                    if (bus.mem_ready) begin
                        hold_d     = bus.mem_data;
                        fetch_pc_d = fetch_pc_q + AW'(1);
                        state_d    = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (bus.mem_ready) begin
                        fetch_pc_d = fetch_pc_q + AW'(1);
                        state_d    = (count_post < FULL) ? FETCH_LO : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            hold_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            hold_q     <= hold_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ir_mem_q[i] <= '0;
                pc_mem_q[i] <= '0;
            end
        end else if (push && !bus.flush) begin
            ir_mem_q[wr_ptr_q] <= {hold_q, bus.mem_data};
            pc_mem_q[wr_ptr_q] <= fetch_pc_q - AW'(1);
        end
    end

    assign bus.mem_req  = (state_q != IDLE);
    assign bus.mem_addr = fetch_pc_q;
    assign bus.ir_valid = (count_q != '0);
    assign bus.ir       = ir_mem_q[rd_ptr_q];
    assign bus.ir_pc    = pc_mem_q[rd_ptr_q];
endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch queue between the bus interface (16-bit bus) and the instruction decoder (32-bit `ir`). It fetches two consecutive 16-bit words per instruction over a req/ready memory handshake and assembles them into a 32-bit instruction. It buffers up to DEPTH instructions with their addresses and presents the oldest to the decoder through a valid/take handshake. A flush from the fetch control unit discards all buffered and in-flight work and restarts fetching at a new address.

## Interface
- DEPTH, 4, number of 32-bit instruction entries; power of two, at least 2.
- AW, 16, word-address width.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  discard queue and in-flight fetch; restart at flush_addr.
- flush_addr  in  AW  word address of the next instruction after a flush.
- mem_req  out  1  fetch request; high in FETCH_LO/FETCH_HI.
- mem_addr  out  AW  word address being fetched; held stable while mem_req is high.
- mem_ready  in  1  sampled on the clock edge; when high, mem_data is valid.
- mem_data  in  16  fetched word.
- ir_valid  out  1  head entry valid (count != 0).
- ir  out  32  head instruction; {first word, second word}.
- ir_pc  out  AW  word address of the head instruction's first word.
- ir_take  in  1  decoder consumes head; ignored when ir_valid=0.

## Operation
- Storage: DEPTH-entry circular buffer of {ir, ir_pc}, with rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap) and count (0..DEPTH).
- Fetch FSM states: IDLE, FETCH_LO, FETCH_HI.
  - IDLE -> FETCH_LO when count < DEPTH (after this cycle's pop); otherwise stays in IDLE.
  - FETCH_LO: mem_addr = fetch_pc. On mem_ready, latch mem_data into hold[15:0], fetch_pc += 1, go to FETCH_HI.
  - FETCH_HI: mem_addr = fetch_pc. On mem_ready, write {hold, mem_data} with pc = fetch_pc-1 at wr_ptr. Then fetch_pc += 1 and go to FETCH_LO if post-update count < DEPTH, else IDLE.
- A new instruction is started only when a free slot exists, and only this block pushes, so a push never overflows.
- Pop on ir_take && ir_valid: rd_ptr += 1. Simultaneous push and pop leaves count unchanged.
- fetch_pc arithmetic is modulo 2^AW: 16'hFFFF + 1 = 16'h0000. An instruction may straddle the wrap.
- Flush (synchronous, highest priority): count=0, rd_ptr=wr_ptr=0, fetch_pc=flush_addr, state=IDLE.
  - mem_ready or ir_take in the same cycle is ignored, and that word is discarded.
  - mem_req drops in the cycle after flush.
- mem_ready while mem_req=0 is ignored.
- Reset (async, reset=0): state=IDLE, fetch_pc=0, pointers and count=0, hold=0, storage=0.
  - Outputs during reset: mem_req=0, mem_addr=0, ir_valid=0, ir=0, ir_pc=0.
  - Reset mid-fetch abandons the fetch immediately.

## Timing
- Outputs are decoded from registered state; there are no combinational paths from inputs to outputs.
- With mem_ready tied high, from the first edge after reset release:
  - cycle 1: FETCH_LO, mem_addr=0.
  - cycle 2: FETCH_HI, mem_addr=1.
  - cycle 3: ir_valid=1.
- Sustained throughput: one instruction per 2 cycles.
- Wait states extend FETCH_LO or FETCH_HI one cycle per low mem_ready; mem_addr is held throughout.
- ir_take pops at the edge; the next entry, or ir_valid=0, is visible in the following cycle.
- Full queue: FSM goes to IDLE. After a pop, FETCH_LO is entered at the next edge. Full-to-refetch is 1 cycle.
- After flush, the first mem_req appears 1 cycle later; the first ir_valid is no earlier than 3 cycles after the flush edge.

## Test plan
- Reset release, mem_ready=1, memory[i]=16'h1000+i, ir_take=0 -> mem_addr sequence 0,1,2,...,7. Entries {1000_1001, pc 0}, {1002_1003, pc 2}, ... DEPTH=4 reached. mem_req=0 and FSM in IDLE after the 4th push.
- Full queue, single ir_take pulse -> ir becomes 32'h1002_1003, ir_pc=2 next cycle. mem_req re-asserts 1 cycle after the pop with mem_addr=8.
- mem_ready low for 3 cycles in FETCH_HI -> mem_addr stays at the odd address, no push, ir_valid unaffected. Push occurs on the first edge with mem_ready=1.
- Flush with flush_addr=16'h0040 while in FETCH_HI, with mem_ready=1 in the same cycle -> ir_valid=0 next cycle, no push from that word. Next fetch addresses are 0x40 and 0x41, then ir_pc=0x40.
- flush_addr=16'hFFFF -> instruction fetched from 0xFFFF then 0x0000, ir_pc=16'hFFFF. The next fetch is at 0x0001.
- reset asserted mid-FETCH_LO with 2 entries buffered -> mem_req=0 and ir_valid=0 immediately, without waiting for a clock edge. After release, fetching restarts at address 0.
